// File: rtl/ram_access_arbiter.sv
// Shares one 2R/1W RAM between requesters A and B: dedicated read ports,
// round-robin write arbitration, and write-first forwarding across requesters.

module ram_access_arbiter_rdport #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  rd,
  input  logic                  byp,
  input  logic [DATA_WIDTH-1:0] fwd_data,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data
);
  logic                  byp_q;
  logic [DATA_WIDTH-1:0] byp_data;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      valid    <= 1'b0;
      byp_q    <= 1'b0;
      byp_data <= '0;
    end else begin
      valid <= rd;
      byp_q <= byp;
      if (byp) byp_data <= fwd_data;
    end
  end

  // The RAM returns the old word on read-during-write; the bypass substitutes the new one.
  assign data = valid ? (byp_q ? byp_data : ram_data) : '0;
endmodule

module ram_access_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iReqA,
  input  logic                  iReqB,
  input  logic                  iWeA,
  input  logic                  iWeB,
  input  logic [ADDR_WIDTH-1:0] iAddrA,
  input  logic [ADDR_WIDTH-1:0] iAddrB,
  input  logic [DATA_WIDTH-1:0] iDataA,
  input  logic [DATA_WIDTH-1:0] iDataB,
  output logic                  oGntA,
  output logic                  oGntB,
  output logic                  oValidA,
  output logic                  oValidB,
  output logic [DATA_WIDTH-1:0] oDataA,
  output logic [DATA_WIDTH-1:0] oDataB,
  output logic                  oRamWriteEnable,
  output logic [ADDR_WIDTH-1:0] oRamWriteAddress,
  output logic [DATA_WIDTH-1:0] oRamDataIn,
  output logic [ADDR_WIDTH-1:0] oRamReadAddress0,
  output logic [ADDR_WIDTH-1:0] oRamReadAddress1,
  input  logic [DATA_WIDTH-1:0] iRamDataOut0,
  input  logic [DATA_WIDTH-1:0] iRamDataOut1
);
  logic prio;  // 0 = A wins a write conflict, 1 = B
  logic wr_a, wr_b, gw_a, gw_b;
  logic same_addr;

  logic [1:0]                 rd, byp, vld;
  logic [1:0][DATA_WIDTH-1:0] fwd, ramq, rdata;

  assign wr_a = iReqA & iWeA;
  assign wr_b = iReqB & iWeB;
  assign gw_a = wr_a & (~wr_b | ~prio);
  assign gw_b = wr_b & (~wr_a |  prio);

  assign oGntA = ~Reset & ((iReqA & ~iWeA) | gw_a);
  assign oGntB = ~Reset & ((iReqB & ~iWeB) | gw_b);

  assign oRamWriteEnable  = ~Reset & (gw_a | gw_b);
  assign oRamWriteAddress = gw_b ? iAddrB : iAddrA;
  assign oRamDataIn       = gw_b ? iDataB : iDataA;
  assign oRamReadAddress0 = iAddrA;
  assign oRamReadAddress1 = iAddrB;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)     prio <= 1'b0;
    else if (gw_a) prio <= 1'b1;
    else if (gw_b) prio <= 1'b0;
  end

  // Lane 0 serves A and forwards from B's write; lane 1 the reverse.
  assign same_addr = (iAddrA == iAddrB);
  assign rd   = {iReqB & ~iWeB, iReqA & ~iWeA};
  assign byp  = {rd[1] & gw_a & same_addr, rd[0] & gw_b & same_addr};
  assign fwd  = {iDataA, iDataB};
  assign ramq = {iRamDataOut1, iRamDataOut0};

  for (genvar i = 0; i < 2; i++) begin : g_rd
    ram_access_arbiter_rdport #(.DATA_WIDTH(DATA_WIDTH)) u_rd (
      .Clock    (Clock),
      .Reset    (Reset),
      .rd       (rd[i]),
      .byp      (byp[i]),
      .fwd_data (fwd[i]),
      .ram_data (ramq[i]),
      .valid    (vld[i]),
      .data     (rdata[i])
    );
  end

  assign oValidA = vld[0];
  assign oValidB = vld[1];
  assign oDataA  = rdata[0];
  assign oDataB  = rdata[1];
endmodule

// File: doc/ram_access_arbiter.md
# ram_access_arbiter

Controller that shares one dual-read-port, single-write-port RAM (registered reads, read-during-write returns old data) between two requesters, A and B. Each requester gets a dedicated read port, so reads never conflict; the single write port is arbitrated round-robin. The block also forwards same-cycle write data so that a requester reading an address the other requester is writing sees the new value. It sits between the RAM instance and its two clients, for example the CPU datapath and a DMA/display fetch unit.

## Interface
- DATA_WIDTH, 16, data word width
- ADDR_WIDTH, 8, address width
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- iReqA / iReqB  in  1  access request from A / B
- iWeA / iWeB  in  1  1 = write, 0 = read (sampled only while the matching iReq is high)
- iAddrA / iAddrB  in  ADDR_WIDTH  access address
- iDataA / iDataB  in  DATA_WIDTH  write data
- oGntA / oGntB  out  1  combinational grant; access is accepted at the rising edge ending the current cycle
- oValidA / oValidB  out  1  read data valid, registered
- oDataA / oDataB  out  DATA_WIDTH  read data; zero whenever the matching oValid is low
- oRamWriteEnable  out  1  to the RAM write enable
- oRamWriteAddress  out  ADDR_WIDTH  to the RAM write address
- oRamDataIn  out  DATA_WIDTH  to the RAM write data
- oRamReadAddress0 / oRamReadAddress1  out  ADDR_WIDTH  RAM read addresses; port 0 is always driven by iAddrA, port 1 by iAddrB
- iRamDataOut0 / iRamDataOut1  in  DATA_WIDTH  RAM registered read data

## Operation
- **Reads:** a read request (iReq=1, iWe=0) is always granted in the same cycle. No arbitration is needed because each requester owns one read port.
- **Single write:** when exactly one requester asks to write, it is granted. The block drives oRamWriteEnable=1 with that requester's address and data.
- **Write conflict:** when both requesters ask to write, the requester holding priority is granted and the other receives gnt=0.
  - The loser must hold its request stable and retry.
- **Priority register prio** (0 = A, 1 = B):
  - After every granted write, prio points to the requester that did not write.
  - Reads do not change prio.
  - Reset sets prio to A.
- **Write-first forwarding:** when one requester's read and the other requester's granted write hit the same address in the same cycle, the read returns the written data instead of the RAM's old word.
  - Forwarding is recorded in a registered bypass flag plus a data register, one pair per requester.
- **Same address, both writing:** the conflict is resolved by normal arbitration, one write per cycle. The final memory content is the loser's data, because it writes last.
- **Write address/data mux:** selects the granted writer. When no write is granted, it holds A's values with enable 0.
- **Reset:** Reset is asynchronous.
  - Clears prio, both valids, both bypass flags and both bypass data registers.
  - Forces oGntA, oGntB and oRamWriteEnable to 0 while asserted.
  - Any read in flight when Reset asserts is discarded and never returns.

## Timing
- A read granted in cycle N gives oValid=1 in cycle N+1 with the RAM word, or the forwarded word.
  - oValid is a single-cycle pulse per granted read.
  - Back-to-back reads give back-to-back valids.
- A write granted in cycle N is committed at the edge ending cycle N. A read of that address by either requester granted in cycle N+1 or later returns the new value.
- A requester's own write and read cannot coincide, because each requester has one iWe.
- Reset values of every output: oGntA=0, oGntB=0, oValidA=0, oValidB=0, oDataA=0, oDataB=0, oRamWriteEnable=0.
  - The RAM address and data outputs follow inputs combinationally, as defined above.
- Maximum write-grant wait under contention is 1 cycle. Round-robin guarantees that no requester starves.

## Test plan
- **Reset:** assert Reset mid-transfer, with a read granted the previous cycle. Required: oValidA=0, oDataA=0 and grants=0 immediately, asynchronously. After release, prio=A.
- **Parallel reads:** A writes 0x1234 to addr 0x05. Next cycle, A and B both read 0x05. Required: cycle+1 gives oValidA=oValidB=1 and oDataA=oDataB=0x1234.
- **Write conflict:** A and B write 0x10 with data 0xAAAA and 0xBBBB, holding requests.
  - Required: cycle 0 gives oGntA=1, oGntB=0; cycle 1 gives oGntB=1.
  - A later read of 0x10 returns 0xBBBB.
- **Round-robin alternation:** both requesters continuously write to distinct addresses for 6 cycles. Required: grants alternate A, B, A, B, A, B, and each address holds its requester's last data.
- **Forwarding:** memory[0x20]=0x0001. In the same cycle, A reads 0x20 and B writes 0x20 with 0xCAFE. Required: next cycle oDataA=0xCAFE, not 0x0001.
- **Idle output gating:** requests stay low. Required: oValid stays 0, oData stays 0 and oRamWriteEnable stays 0 for all cycles.
